rsp_split: RTL and testbench

// - Response-side counterpart of the stream request merge.
// - Takes one response stream tagged with a stream id (i_sel) and routes each beat to the per-stream port it names.
// - Each stream has its own DEPTH-entry FIFO, so one stalled consumer does not block the others until its own FIFO fills.
// - Sits between the shared OpenCAPI response path and the per-stream buffers.

---
 rtl/rsp_split.sv | 93 +++++++++
 tb/tb_rsp_split.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsp_split.sv
// Response splitter: routes each tagged input beat into a per-stream FIFO and
// presents every FIFO head on its own output port. Optional RSP_SPLIT_BYPASS_EN adds cut-through.
module rsp_split #(
    parameter int WAYS  = 16,
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_v,
    output logic                     i_r,
    input  logic [WIDTH-1:0]         i_d,
    input  logic [$clog2(WAYS)-1:0]  i_sel,
    output logic [WAYS-1:0]          o_v,
    input  logic [WAYS-1:0]          o_r,
    output logic [WAYS*WIDTH-1:0]    o_d,
    output logic                     o_idle
);

    localparam int SW = $clog2(WAYS);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    rd_q [WAYS];
    logic [PW-1:0]    rd_d [WAYS];
    logic [PW-1:0]    wr_q [WAYS];
    logic [PW-1:0]    wr_d [WAYS];
    logic [WIDTH-1:0] mem_q [WAYS][DEPTH];

    logic [WAYS-1:0] hit;
    logic [WAYS-1:0] empty;
    logic [WAYS-1:0] full;
    logic [WAYS-1:0] byp;
    logic [WAYS-1:0] push;
    logic [WAYS-1:0] pop;

    // The wrap bit distinguishes full from empty when the low pointer bits match.
    always_comb begin
        hit   = '0;
        empty = '0;
        full  = '0;
        byp   = '0;
        push  = '0;
        pop   = '0;
        o_v   = '0;
        o_d   = '0;
        for (int s = 0; s < WAYS; s++) begin
            rd_d[s]  = rd_q[s];
            wr_d[s]  = wr_q[s];
            hit[s]   = i_v && (i_sel == SW'(s));
            empty[s] = (rd_q[s] == wr_q[s]);
            full[s]  = (rd_q[s][AW-1:0] == wr_q[s][AW-1:0]) && (rd_q[s][AW] != wr_q[s][AW]);
`ifdef RSP_SPLIT_BYPASS_EN
            // Cut-through only from an empty FIFO; valid never looks at this slot's ready.
            byp[s] = hit[s] && empty[s] && o_r[s];
            o_v[s] = !empty[s] || hit[s];
            o_d[s*WIDTH +: WIDTH] = empty[s] ? i_d : mem_q[s][rd_q[s][AW-1:0]];
`else
            o_v[s] = !empty[s];
            o_d[s*WIDTH +: WIDTH] = mem_q[s][rd_q[s][AW-1:0]];
`endif
            push[s] = hit[s] && !full[s] && !byp[s];
            pop[s]  = !empty[s] && o_r[s];
            rd_d[s] = rd_q[s] + PW'(pop[s]);
            wr_d[s] = wr_q[s] + PW'(push[s]);
        end
    end

    assign i_r    = !full[i_sel];
    assign o_idle = (&empty) && !i_v;

    // NOTE: storage is reset as well so o_d reads 0 out of reset, not stale data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < WAYS; s++) begin
                rd_q[s] <= '0;
                wr_q[s] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem_q[s][e] <= '0;
                end
            end
        end else begin
            for (int s = 0; s < WAYS; s++) begin
                rd_q[s] <= rd_d[s];
                wr_q[s] <= wr_d[s];
                if (push[s]) begin
                    mem_q[s][wr_q[s][AW-1:0]] <= i_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_rsp_split.sv
// Scoreboard bench for rsp_split: per-stream expected queues filled by the
// stimulus, drained and compared by an independent negedge monitor.
module tb_rsp_split;

    localparam int WAYS  = 16;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SW    = $clog2(WAYS);
`ifdef RSP_SPLIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                  clk;
    logic                  reset;
    logic                  i_v;
    logic                  i_r;
    logic [WIDTH-1:0]      i_d;
    logic [SW-1:0]         i_sel;
    logic [WAYS-1:0]       o_v;
    logic [WAYS-1:0]       o_r;
    logic [WAYS*WIDTH-1:0] o_d;
    logic                  o_idle;

    rsp_split #(.WAYS(WAYS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .i_v   (i_v),
        .i_r   (i_r),
        .i_d   (i_d),
        .i_sel (i_sel),
        .o_v   (o_v),
        .o_r   (o_r),
        .o_d   (o_d),
        .o_idle(o_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;
    bit pend   = 1'b0;

    // Reference model: beats accepted but not yet delivered, per stream, in order.
    logic [WIDTH-1:0] exp_q [WAYS][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model decides acceptance from stream occupancy alone.
    task automatic drive(input bit v, input int sel, input logic [WIDTH-1:0] d,
                         input logic [WAYS-1:0] rdy, output bit acc);
        @(posedge clk);
        #1;
        i_v   = v;
        i_sel = SW'(sel);
        i_d   = d;
        o_r   = rdy;
        acc   = v && (exp_q[sel].size() < DEPTH);
        pend  = acc;
        if (acc) begin
            exp_q[sel].push_back(d);
            n_in++;
        end
    endtask

    task automatic idle(input int n, input logic [WAYS-1:0] rdy);
        bit acc;
        repeat (n) drive(1'b0, 0, '0, rdy, acc);
    endtask

    task automatic send(input int sel, input logic [WIDTH-1:0] d, input logic [WAYS-1:0] rdy);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 50) begin
            drive(1'b1, sel, d, rdy, acc);
            tries++;
        end
        if (!acc) check("send_timeout", 64'(tries), 64'd0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_o_v"}, 64'(o_v), 64'd0);
        check({tag, "_o_d"}, 64'(o_d[63:0]), 64'd0);
        check({tag, "_o_d_hi"}, 64'(o_d[WAYS*WIDTH-1:64]), 64'd0);
        check({tag, "_i_r"}, 64'(i_r), 64'd1);
        check({tag, "_o_idle"}, 64'(o_idle), 64'd1);
    endtask

    // Monitor: compare every output against the model, then retire delivered beats.
    int  occ [WAYS];
    bit  all_empty;
    bit  exp_v;
    always @(negedge clk) begin
        if (!reset) begin
            all_empty = 1'b1;
            for (int s = 0; s < WAYS; s++) begin
                occ[s] = exp_q[s].size() - ((pend && (int'(i_sel) == s)) ? 1 : 0);
                if (occ[s] != 0) all_empty = 1'b0;
            end
            check("i_r", 64'(i_r), 64'(occ[i_sel] < DEPTH));
            check("o_idle", 64'(o_idle), 64'(all_empty && !i_v));
            for (int s = 0; s < WAYS; s++) begin
                exp_v = (occ[s] > 0) || (BYP && i_v && (int'(i_sel) == s));
                check($sformatf("o_v[%0d]", s), 64'(o_v[s]), 64'(exp_v));
                if (exp_v && o_v[s]) begin
                    check($sformatf("o_d[%0d]", s), 64'(o_d[s*WIDTH +: WIDTH]), 64'(exp_q[s][0]));
                end
                if (o_v[s] && o_r[s] && exp_q[s].size() > 0) begin
                    void'(exp_q[s].pop_front());
                    n_out++;
                end
            end
        end
    end

    initial begin
        bit              acc;
        logic [WAYS-1:0] rdy;
        int              left;
        int              budget;

        reset = 1'b1;
        i_v   = 1'b0;
        i_sel = '0;
        i_d   = '0;
        o_r   = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Sweep every stream once at full rate with all consumers ready.
        for (int k = 0; k < WAYS; k++) drive(1'b1, k, WIDTH'(k), '1, acc);
        idle(3, '1);

        // Stream 3 blocked: four beats fill it, the fifth stalls until a pop.
        rdy    = '1;
        rdy[3] = 1'b0;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 3, WIDTH'(8'h30 + i), rdy, acc);
        repeat (3) drive(1'b1, 3, 8'h34, rdy, acc);
        send(3, 8'h34, '1);
        idle(DEPTH + 2, '1);

        // Stream 5 holding two entries, then push and pop in the same cycle.
        rdy    = '1;
        rdy[5] = 1'b0;
        drive(1'b1, 5, 8'h50, rdy, acc);
        drive(1'b1, 5, 8'h51, rdy, acc);
        drive(1'b1, 5, 8'h52, '1, acc);
        drive(1'b1, 5, 8'h53, '1, acc);
        idle(4, '1);

        // Pointer wrap on stream 2: repeated fill/drain and streaming.
        rdy    = '1;
        rdy[2] = 1'b0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i <= DEPTH; i++) drive(1'b1, 2, WIDTH'(8'h20 + r * 8 + i), rdy, acc);
            idle(DEPTH + 1, '1);
            for (int i = 0; i < DEPTH; i++) drive(1'b1, 2, WIDTH'(8'ha0 + r * 8 + i), '1, acc);
            idle(2, '1);
        end

        // Reset in the middle of traffic discards every queued beat.
        for (int i = 0; i < 10; i++) drive(1'b1, i % 4, WIDTH'(8'hc0 + i), '0, acc);
        @(posedge clk);
        #1;
        reset = 1'b1;
        i_v   = 1'b0;
        pend  = 1'b0;
        for (int s = 0; s < WAYS; s++) begin
            n_in -= exp_q[s].size();
            exp_q[s].delete();
        end
        #1;
        reset_checks("mid");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2, '1);

        // Random traffic with random consumer readiness.
        for (int n = 0; n < 12000; n++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, WAYS - 1),
                  WIDTH'($urandom), WAYS'($urandom), acc);
        end

        // Drain everything and confirm nothing was lost or duplicated.
        budget = 0;
        left   = 1;
        while (left != 0 && budget < 200) begin
            idle(1, '1);
            left = 0;
            for (int s = 0; s < WAYS; s++) left += exp_q[s].size();
            budget++;
        end
        idle(2, '1);
        check("drain_left", 64'(left), 64'd0);
        check("beats_delivered", 64'(n_out), 64'(n_in));
        check("final_idle", 64'(o_idle), 64'd1);
        check("final_o_v", 64'(o_v), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
